// File: rtl/q_table_pkg.sv
// q_table_pkg
// Shared constants and types for the nine-bank Q-value store:
//   - table geometry (Q_WIDTH, STATE_WIDTH, DEPTH, ADDR_WIDTH)
//   - 2-bit board cell codes and the base-3 place values POW3
//   - controller state encoding (INIT sweep / RUN)
//   - multi_hot(): true when more than one action-select bit is set
package q_table_pkg;

    localparam int Q_WIDTH     = 16;
    localparam int STATE_WIDTH = 18;
    localparam int DEPTH       = 19683;   // 3^9 board positions
    localparam int ADDR_WIDTH  = 15;      // ceil(log2(DEPTH))
    localparam int NUM_CELLS   = 9;
    localparam int NUM_BANKS   = 9;       // one bank per action

    // Board cell codes, two bits per cell
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_AGENT = 2'b01;
    localparam logic [1:0] CELL_USER  = 2'b10;
    localparam logic [1:0] CELL_BAD   = 2'b11;

    // Place value of cell i in the dense base-3 index
    localparam logic [ADDR_WIDTH-1:0] POW3 [0:NUM_CELLS-1] = '{
        15'd1, 15'd3, 15'd9, 15'd27, 15'd81,
        15'd243, 15'd729, 15'd2187, 15'd6561
    };

    typedef enum logic {
        INIT = 1'b0,   // zeroing sweep in progress
        RUN  = 1'b1    // normal read/write service
    } fsm_t;

    // Clearing the lowest set bit leaves something only if two or more
    // bits were set; zero and one-hot both return 0.
    function automatic logic multi_hot(input logic [NUM_BANKS-1:0] v);
        return (v & (v - NUM_BANKS'(1))) != '0;
    endfunction

endpackage

// File: rtl/q_table_bank_state_to_index.sv
// state_to_index
// Registered base-3 encoder: turns a packed 9-cell board state into the
// dense table index sum(digit_i * 3^i) and flags any cell coded 2'b11.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-high
//   state   in   STATE_WIDTH packed board, cell i at bits [2i+1:2i]
//   index   out  ADDR_WIDTH registered index (0..DEPTH-1 for valid states)
//   invalid out  registered flag, high when some cell holds 2'b11
module state_to_index
    import q_table_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] state,
    output logic [ADDR_WIDTH-1:0]  index,
    output logic                   invalid
);

    logic [ADDR_WIDTH-1:0] index_c;
    logic [ADDR_WIDTH-1:0] digit;
    logic                  invalid_c;

    // A bad cell contributes digit 0; the invalid flag keeps the
    // resulting index from ever being used.
    always_comb begin
        index_c   = '0;
        digit     = '0;
        invalid_c = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            case (state[2*i +: 2])
                CELL_EMPTY: digit = ADDR_WIDTH'(0);
                CELL_AGENT: digit = ADDR_WIDTH'(1);
                CELL_USER:  digit = ADDR_WIDTH'(2);
                CELL_BAD: begin
                    digit     = ADDR_WIDTH'(0);
                    invalid_c = 1'b1;
                end
                default:    digit = ADDR_WIDTH'(0);
            endcase
            index_c = index_c + digit * POW3[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            index   <= '0;
            invalid <= 1'b0;
        end else begin
            index   <= index_c;
            invalid <= invalid_c;
        end
    end

endmodule

// File: rtl/q_table_bank.sv
// q_table_bank
// Nine-bank Q-value store indexed by compressed board state. After every
// reset an INIT sweep zeroes all nine banks one address per cycle; RUN
// then serves one write and one nine-wide read per cycle.
// Pipeline: edge N registers index/validity (and write data/select);
// edge N+1 commits the write and captures the read. A write committing at
// N+1 to the index being read is forwarded onto that bank's output.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   rd_state                state whose nine Q values are returned
//   wr_state                state being updated
//   wr_data                 Q value to store
//   wr_en[8:0]              bank select, bit k-1 selects action k
//   Q_value_act1..9         Q values for rd_state, latency 2
//   init_done               high once the zeroing sweep is complete
//   wr_error                one-cycle pulse: wr_en had 2+ bits set
//   invalid_state           one-cycle pulse: rd_state or wr_state had a 2'b11 cell
module q_table_bank
    import q_table_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [STATE_WIDTH-1:0] rd_state,
    input  logic [STATE_WIDTH-1:0] wr_state,
    input  logic [Q_WIDTH-1:0]     wr_data,
    input  logic [NUM_BANKS-1:0]   wr_en,
    output logic [Q_WIDTH-1:0]     Q_value_act1,
    output logic [Q_WIDTH-1:0]     Q_value_act2,
    output logic [Q_WIDTH-1:0]     Q_value_act3,
    output logic [Q_WIDTH-1:0]     Q_value_act4,
    output logic [Q_WIDTH-1:0]     Q_value_act5,
    output logic [Q_WIDTH-1:0]     Q_value_act6,
    output logic [Q_WIDTH-1:0]     Q_value_act7,
    output logic [Q_WIDTH-1:0]     Q_value_act8,
    output logic [Q_WIDTH-1:0]     Q_value_act9,
    output logic                   init_done,
    output logic                   wr_error,
    output logic                   invalid_state
);

    // ------------------------------------------------------------------
    // Controller: INIT sweep then RUN
    // ------------------------------------------------------------------
    fsm_t                  fsm_state;
    fsm_t                  fsm_next;
    logic [ADDR_WIDTH-1:0] sweep_cnt;
    logic                  sweep_last;
    logic                  in_init;

    assign sweep_last = (sweep_cnt == ADDR_WIDTH'(DEPTH - 1));
    assign in_init    = (fsm_state == INIT);
    assign init_done  = (fsm_state == RUN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) fsm_state <= INIT;
        else       fsm_state <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_state;
        case (fsm_state)
            INIT:    if (sweep_last) fsm_next = RUN;
            RUN:     fsm_next = RUN;
            default: fsm_next = INIT;
        endcase
    end

    // Counter sits at 0 outside INIT so a later reset always restarts cleanly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_cnt <= '0;
        end else if (in_init) begin
            sweep_cnt <= sweep_last ? '0 : sweep_cnt + ADDR_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: index encoders and write-side registers
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_bad;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic                  wr_bad;
    logic [Q_WIDTH-1:0]    wr_data_q;
    logic [NUM_BANKS-1:0]  wr_en_q;

    state_to_index u_rd_index (
        .clock   (clock),
        .reset   (reset),
        .state   (rd_state),
        .index   (rd_idx),
        .invalid (rd_bad)
    );

    state_to_index u_wr_index (
        .clock   (clock),
        .reset   (reset),
        .state   (wr_state),
        .index   (wr_idx),
        .invalid (wr_bad)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_data_q <= '0;
            wr_en_q   <= '0;
        end else begin
            wr_data_q <= wr_data;
            wr_en_q   <= wr_en;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: write commit, bank read, forwarding and status pulses
    // ------------------------------------------------------------------
    logic                  wr_multi;
    logic                  wr_commit;
    logic [NUM_BANKS-1:0]  bank_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [Q_WIDTH-1:0]    mem_din;
    logic                  same_idx;

    assign wr_multi  = multi_hot(wr_en_q);
    // wr_en_q == 0 leaves every bank_we bit low, so zero needs no special case.
    assign wr_commit = !in_init && !wr_bad && !wr_multi;
    assign same_idx  = (wr_idx == rd_idx);

    // The sweep owns the single write port of every bank during INIT.
    assign bank_we  = in_init ? {NUM_BANKS{1'b1}} : (wr_en_q & {NUM_BANKS{wr_commit}});
    assign mem_addr = in_init ? sweep_cnt : wr_idx;
    assign mem_din  = in_init ? '0 : wr_data_q;

    logic [NUM_BANKS-1:0]              fwd_hit;
    logic [Q_WIDTH-1:0]                fwd_data;
    logic                              out_zero;
    logic [NUM_BANKS-1:0][Q_WIDTH-1:0] q_out;

    // Flags beside the RAM outputs: the RAM read register itself has no
    // reset, so out_zero (reset high) masks it until a valid RUN read lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_hit       <= '0;
            fwd_data      <= '0;
            out_zero      <= 1'b1;
            wr_error      <= 1'b0;
            invalid_state <= 1'b0;
        end else begin
            fwd_hit       <= wr_en_q & {NUM_BANKS{wr_commit && same_idx}};
            fwd_data      <= wr_data_q;
            out_zero      <= in_init || rd_bad;
            wr_error      <= wr_multi;
            invalid_state <= rd_bad || wr_bad;
        end
    end

    // One simple dual-port array per action; read-before-write on a shared
    // address, so a same-cycle write is supplied by the forwarding mux.
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        logic [Q_WIDTH-1:0] mem [DEPTH];
        logic [Q_WIDTH-1:0] rd_raw;

        always_ff @(posedge clock) begin
            if (bank_we[k]) mem[mem_addr] <= mem_din;
            rd_raw <= mem[rd_idx];
        end

        assign q_out[k] = out_zero   ? '0       :
                          fwd_hit[k] ? fwd_data : rd_raw;
    end

    assign Q_value_act1 = q_out[0];
    assign Q_value_act2 = q_out[1];
    assign Q_value_act3 = q_out[2];
    assign Q_value_act4 = q_out[3];
    assign Q_value_act5 = q_out[4];
    assign Q_value_act6 = q_out[5];
    assign Q_value_act7 = q_out[6];
    assign Q_value_act8 = q_out[7];
    assign Q_value_act9 = q_out[8];

endmodule

// File: tb/tb_q_table_bank.sv
// tb_q_table_bank
// Self-checking bench for q_table_bank. A reference table (plain array of
// nine banks indexed by the base-3 board number) predicts each read; the
// prediction for a transaction is queued when it is sampled and compared
// one edge later, when its registered outputs appear.
module tb_q_table_bank;

    localparam int TB_DEPTH = 19683;

    logic        clock;
    logic        reset;
    logic [17:0] rd_state;
    logic [17:0] wr_state;
    logic [15:0] wr_data;
    logic [8:0]  wr_en;
    logic [15:0] Q_value_act1, Q_value_act2, Q_value_act3;
    logic [15:0] Q_value_act4, Q_value_act5, Q_value_act6;
    logic [15:0] Q_value_act7, Q_value_act8, Q_value_act9;
    logic        init_done;
    logic        wr_error;
    logic        invalid_state;

    q_table_bank dut (
        .clock         (clock),
        .reset         (reset),
        .rd_state      (rd_state),
        .wr_state      (wr_state),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .Q_value_act1  (Q_value_act1),
        .Q_value_act2  (Q_value_act2),
        .Q_value_act3  (Q_value_act3),
        .Q_value_act4  (Q_value_act4),
        .Q_value_act5  (Q_value_act5),
        .Q_value_act6  (Q_value_act6),
        .Q_value_act7  (Q_value_act7),
        .Q_value_act8  (Q_value_act8),
        .Q_value_act9  (Q_value_act9),
        .init_done     (init_done),
        .wr_error      (wr_error),
        .invalid_state (invalid_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [17:0] rs;
        logic [17:0] ws;
        logic [15:0] wd;
        logic [8:0]  we;
    } tx_t;

    logic [15:0]  ref_mem [9][TB_DEPTH];
    bit           model_run;
    logic [145:0] exp_q[$];   // {invalid_state, wr_error, act9..act1}
    int           n_checks;
    int           n_fail;

    function automatic bit state_bad(input logic [17:0] s);
        for (int i = 0; i < 9; i++)
            if (s[2*i +: 2] == 2'b11) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int cell_idx(input logic [17:0] s);
        int acc = 0;
        int pw  = 1;
        for (int i = 0; i < 9; i++) begin
            acc += int'(s[2*i +: 2]) * pw;
            pw  *= 3;
        end
        return acc;
    endfunction

    function automatic logic [17:0] rand_state();
        logic [17:0] s;
        for (int i = 0; i < 9; i++) s[2*i +: 2] = 2'($urandom_range(0, 2));
        return s;
    endfunction

    function automatic logic [145:0] obs_vec();
        return {invalid_state, wr_error, Q_value_act9, Q_value_act8, Q_value_act7,
                Q_value_act6, Q_value_act5, Q_value_act4, Q_value_act3,
                Q_value_act2, Q_value_act1};
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 9; k++)
            for (int a = 0; a < TB_DEPTH; a++) ref_mem[k][a] = 16'h0;
    endtask

    // Present one transaction for one edge; predict what it shows one edge later.
    // A read sees a write presented in the same cycle.
    task automatic drive(input tx_t t);
        logic [143:0] q;
        bit           err;
        bit           inv;
        rd_state = t.rs;
        wr_state = t.ws;
        wr_data  = t.wd;
        wr_en    = t.we;
        @(posedge clock);
        err = ($countones(t.we) > 1);
        inv = state_bad(t.rs) || state_bad(t.ws);
        if (model_run && !state_bad(t.ws) && $countones(t.we) == 1)
            for (int k = 0; k < 9; k++)
                if (t.we[k]) ref_mem[k][cell_idx(t.ws)] = t.wd;
        q = '0;
        if (model_run && !state_bad(t.rs))
            for (int k = 0; k < 9; k++) q[16*k +: 16] = ref_mem[k][cell_idx(t.rs)];
        exp_q.push_back({inv, err, q});
        #1;
    endtask

    task automatic idle_inputs();
        rd_state = 18'h0;
        wr_state = 18'h0;
        wr_data  = 16'h0;
        wr_en    = 9'h0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int done_at = -1;
        int nz      = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (obs_vec() !== 146'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init_done: got %b want 0", init_done);
        end
        reset = 1'b0;
        // Writes offered early in the sweep must never appear later.
        for (int n = 1; n <= 20000; n++) begin
            rd_state = rand_state();
            wr_state = rand_state();
            wr_data  = 16'($urandom);
            wr_en    = (n < 100) ? 9'(1 << $urandom_range(0, 8)) : 9'h0;
            @(posedge clock);
            #1;
            if (init_done === 1'b1) begin
                done_at = n;
                break;
            end
            if (obs_vec() !== 146'h0) nz++;
        end
        n_checks++;
        if (done_at != TB_DEPTH) begin
            n_fail++;
            $display("FAIL init_sweep_len: init_done after %0d edges, want %0d", done_at, TB_DEPTH);
        end
        n_checks++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL init_outputs_zero: %0d nonzero cycles, want 0", nz);
        end
        clear_model();
        model_run = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_post_init_read();
        logic [145:0] e;
        for (int i = 0; i <= 8; i++) begin
            drive('{rs: (i == 8) ? 18'h0 : rand_state(), ws: 18'h0, wd: 16'h0, we: 9'h0});
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL post_init_read %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_basic_write();
        tx_t          seq[$];
        logic [145:0] e;
        logic [143:0] want_const;
        seq = '{'{rs: 18'h15555, ws: 18'h0,   wd: 16'h1234, we: 9'b000000100},
                '{rs: 18'h0,     ws: 18'h0,   wd: 16'h0,    we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0,   wd: 16'h0,    we: 9'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL basic_write %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        // Read of state 0 presented one cycle after the write: only act3 is set.
        want_const = '0;
        want_const[32 +: 16] = 16'h1234;
        n_checks++;
        if (obs_vec() !== {2'b00, want_const}) begin
            n_fail++;
            $display("FAIL basic_write_act3: got %h want %h", obs_vec(), {2'b00, want_const});
        end
        exp_q.delete();
    endtask

    task automatic test_index_distinct();
        tx_t          seq[$];
        logic [145:0] e;
        seq = '{'{rs: 18'h0, ws: 18'h00001, wd: 16'h00AA, we: 9'b000000001},
                '{rs: 18'h0, ws: 18'h00004, wd: 16'h00BB, we: 9'b000000001},
                '{rs: 18'h00001, ws: 18'h0, wd: 16'h0, we: 9'h0},
                '{rs: 18'h00004, ws: 18'h0, wd: 16'h0, we: 9'h0},
                '{rs: 18'h00002, ws: 18'h0, wd: 16'h0, we: 9'h0},
                '{rs: 18'h00010, ws: 18'h0, wd: 16'h0, we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0, wd: 16'h0, we: 9'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL index_distinct %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_multi_hot();
        tx_t          seq[$];
        logic [145:0] e;
        seq = '{'{rs: 18'h0,     ws: 18'h00009, wd: 16'h5555, we: 9'b000000010},
                '{rs: 18'h00009, ws: 18'h00009, wd: 16'hFFFF, we: 9'b000000011},
                '{rs: 18'h00009, ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h00009, ws: 18'h00009, wd: 16'hFFFF, we: 9'b110000000},
                '{rs: 18'h00009, ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0,     wd: 16'h0,    we: 9'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL multi_hot %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_invalid_state();
        tx_t          seq[$];
        logic [145:0] e;
        seq = '{'{rs: 18'h0,     ws: 18'h00003, wd: 16'h7777, we: 9'b000000001},
                '{rs: 18'h00003, ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h30000, ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0,     wd: 16'h0,    we: 9'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL invalid_state %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_collision();
        tx_t          seq[$];
        logic [145:0] e;
        seq = '{'{rs: 18'h0,     ws: 18'h00005, wd: 16'h1111, we: 9'b000010000},
                '{rs: 18'h0,     ws: 18'h00005, wd: 16'h3333, we: 9'b000000010},
                '{rs: 18'h00005, ws: 18'h00005, wd: 16'h2222, we: 9'b000010000},
                '{rs: 18'h00005, ws: 18'h00005, wd: 16'h4444, we: 9'b100000000},
                '{rs: 18'h00005, ws: 18'h0,     wd: 16'h0,    we: 9'h0},
                '{rs: 18'h0,     ws: 18'h0,     wd: 16'h0,    we: 9'h0}};
        for (int i = 0; i < seq.size(); i++) begin
            drive(seq[i]);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL collision %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [17:0]  pool [6];
        logic [145:0] e;
        tx_t          t;
        int           r;
        int           a;
        int           b;
        pool[0] = 18'h0;
        for (int p = 1; p < 6; p++) pool[p] = rand_state();
        for (int i = 0; i <= 400; i++) begin
            t.rs = pool[$urandom_range(0, 5)];
            t.ws = pool[$urandom_range(0, 5)];
            if ($urandom_range(0, 19) == 0) t.rs[2*$urandom_range(0, 8) +: 2] = 2'b11;
            if ($urandom_range(0, 19) == 0) t.ws[2*$urandom_range(0, 8) +: 2] = 2'b11;
            t.wd = 16'($urandom);
            r = $urandom_range(0, 9);
            a = $urandom_range(0, 8);
            b = (a + $urandom_range(1, 8)) % 9;
            if (r == 0)      t.we = 9'h0;
            else if (r == 1) t.we = 9'((1 << a) | (1 << b));
            else             t.we = 9'(1 << a);
            if (i == 400) t = '{rs: 18'h0, ws: 18'h0, wd: 16'h0, we: 9'h0};
            drive(t);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL back_to_back %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_op();
        logic [17:0]  s;
        logic [145:0] e;
        int           early   = 0;
        int           done_at = -1;
        s = rand_state();
        for (int i = 0; i < 3; i++) begin
            drive('{rs: s, ws: s, wd: 16'hBEEF, we: (i == 0) ? 9'b100000000 : 9'h0});
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL pre_reset_read %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        // Asynchronous reset in RUN, away from any clock edge.
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs_vec() !== 146'h0) begin
            n_fail++;
            $display("FAIL async_reset_outputs: got %h want 0", obs_vec());
        end
        n_checks++;
        if (init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_init_done: got %b want 0", init_done);
        end
        exp_q.delete();
        model_run = 1'b0;
        idle_inputs();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int n = 1; n <= 5000; n++) begin
            @(posedge clock);
            #1;
            if (init_done !== 1'b0) early++;
        end
        n_checks++;
        if (early != 0) begin
            n_fail++;
            $display("FAIL mid_sweep_init_done: high on %0d cycles, want 0", early);
        end
        // Sweep count is now 5000; reset again and require a full sweep.
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int n = 1; n <= 20000; n++) begin
            @(posedge clock);
            #1;
            if (init_done === 1'b1) begin
                done_at = n;
                break;
            end
        end
        n_checks++;
        if (done_at != TB_DEPTH) begin
            n_fail++;
            $display("FAIL restart_sweep_len: init_done after %0d edges, want %0d", done_at, TB_DEPTH);
        end
        clear_model();
        model_run = 1'b1;
        // The earlier BEEF must have been swept away.
        for (int i = 0; i <= 6; i++) begin
            drive('{rs: (i == 0) ? s : rand_state(), ws: 18'h0, wd: 16'h0, we: 9'h0});
            if (i > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (obs_vec() !== e) begin
                    n_fail++;
                    $display("FAIL post_restart_read %0d: got %h want %h", i, obs_vec(), e);
                end
            end
        end
        exp_q.delete();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_run = 1'b0;
        reset     = 1'b1;
        idle_inputs();
        test_reset();
        test_post_init_read();
        test_basic_write();
        test_index_distinct();
        test_multi_hot();
        test_invalid_state();
        test_collision();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
